irq_dispatch: RTL and testbench
===============================

Name: irq_dispatch

Overview:
- Sequential interrupt front/back end wrapped around the 8-input priority encoder.
- Synchronizes and latches 8 request lines into a pending register, applies a mask, and drives the masked pending vector into the encoder's y input.
- Consumes the encoder's code and valid outputs ({a,b,c} and d), then runs a valid/ready offer to the CPU followed by an end-of-interrupt (EOI) in-service phase.

Parameters:
SYNC_STAGES, 2, flops in each irq_in synchronizer chain (>=2)
EDGE_MODE, 1, 1 = rising-edge-latched pending bits; 0 = level-sensitive pending

Ports:
clk  in  1  system clock, all flops rising edge
rst_n  in  1  asynchronous active-low reset
irq_in  in  [0:7]  asynchronous request lines; bit i = source i
mask  in  [0:7]  1 = source i masked (blocked from encoder), synchronous to clk
pend_vec  out  [0:7]  pending & ~mask & ~isr_block, drives encoder y[0:7]
enc_code  in  3  encoder {a,b,c}; equals index of highest set pend_vec bit (bit 7 highest)
enc_valid  in  1  encoder d; 1 when any pend_vec bit set
vec_valid  out  1  interrupt offer to CPU
vec_id  out  3  offered source index, stable while vec_valid
vec_ready  in  1  CPU accepts offer
eoi  in  1  one-cycle end-of-interrupt pulse from CPU
in_service  out  1  an accepted interrupt awaits EOI
pending  out  [0:7]  raw pending register (status)

Behaviour:
- Reset (async assert, sync-release assumed by SoC): pending=0, synchronizers=0, edge history=0, state=IDLE, vec_valid=0, vec_id=0, in_service=0.
- Synchronizer: irq_in bit -> SYNC_STAGES flops -> s[i]; edge history flop h[i]=s[i] delayed 1.
- EDGE_MODE=1:
  - pending[i] set on s[i]&~h[i].
  - pending[i] cleared on accept of source i.
  - Set and clear in the same cycle: set wins, bit stays 1.
  - Masked sources still latch and stay pending.
- EDGE_MODE=0: pending[i]=s[i] each cycle. The accept/clear path is inert; the source must drop its level before EOI.
- pend_vec is combinational from registers: pending & ~mask, forced to all-zero while state != IDLE, so the encoder output is consulted only in IDLE.
- FSM, states IDLE, OFFER, SERVICE:
  - IDLE: if enc_valid -> capture vec_id<=enc_code, go OFFER. Latency is 1 cycle from pend_vec nonzero to vec_valid=1.
  - OFFER: vec_valid=1. vec_id is frozen regardless of new requests or mask changes (no withdrawal). On vec_ready=1: clear pending[vec_id] (edge mode), go SERVICE.
  - SERVICE: vec_valid=0, in_service=1. On eoi=1 -> IDLE. The next offer can appear 1 cycle after the EOI cycle.
- eoi outside SERVICE is ignored. vec_ready outside OFFER is ignored.
- vec_ready and eoi in the same cycle while in OFFER: accept only; the eoi is ignored.
- Reset mid-operation: all state is discarded immediately and pending requests are lost; sources must re-request.
- Encoder combinational delay must fit within one clk period from pend_vec to the enc_code/enc_valid capture.

Decomposition:
- Shared package irq_pkg:
  - N_SRC=8
  - ID_W=3
  - FSM state encoding: IDLE=2'b00, OFFER=2'b01, SERVICE=2'b10
- One natural sub-module: irq_sync_edge. It holds the per-bit SYNC_STAGES synchronizer plus the edge detector, is instantiated as a vector of 8, and outputs s and rise.
- The existing priority encoder is instantiated at the parent level, not inside irq_dispatch.

Test Plan:
1. Reset, then irq_in[3] rising edge (EDGE_MODE=1, mask=0) -> pending=8'b00010000 after SYNC_STAGES+1 cycles; vec_valid=1 with vec_id=3 one cycle later.
2. Simultaneous edges on sources 1 and 6 -> vec_id=6 first. After vec_ready and eoi -> vec_id=1 offered; pending=0 once both are accepted.
3. Source 5 pending with mask[5]=1 -> vec_valid stays 0 and pending[5]=1. Clear mask[5] -> vec_id=5 offered 1 cycle later.
4. During OFFER of id 2, new edge on source 7 -> vec_id holds 2 until accept. Source 7 is offered only after eoi.
5. Accept cycle for id 4 coincides with a new rising edge on source 4 -> pending[4] remains 1, and id 4 is re-offered after eoi.
6. Assert rst_n=0 during SERVICE -> vec_valid=0, in_service=0, pending=0 asynchronously; after release no offer occurs without new edges.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatcher: source count, id width, FSM encoding.
package irq_pkg;
  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OFFER   = 2'b01,
    SERVICE = 2'b10
  } state_t;
endpackage

// File: rtl/irq_sync_edge.sv
// One request line: SYNC_STAGES-deep synchronizer followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      h     <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      h     <= s;
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~h;
endmodule

// File: rtl/irq_dispatch.sv
// Interrupt front/back end around an external priority encoder: latches requests,
// offers the encoder's winner to the CPU with valid/ready, then holds it in service until EOI.
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [0:N_SRC-1] irq_in,
  input  logic [0:N_SRC-1] mask,
  output logic [0:N_SRC-1] pend_vec,
  input  logic [ID_W-1:0] enc_code,
  input  logic            enc_valid,
  output logic            vec_valid,
  output logic [ID_W-1:0] vec_id,
  input  logic            vec_ready,
  input  logic            eoi,
  output logic            in_service,
  output logic [0:N_SRC-1] pending
);
  state_t           state;
  logic [0:N_SRC-1] s;
  logic [0:N_SRC-1] rise;
  logic [0:N_SRC-1] pending_nxt;
  logic             accept;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (irq_in[i]),
      .s    (s[i]),
      .rise (rise[i])
    );
  end

  assign accept = (state == OFFER) && vec_ready;

  // A new edge on the source being accepted wins over the clear, so it is not lost.
  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (EDGE_MODE != 0)
        pending_nxt[i] = rise[i] | (pending[i] & ~(accept && (vec_id == ID_W'(i))));
      else
        pending_nxt[i] = s[i];
    end
  end

  // Encoder only sees requests in IDLE, so its output is never stale when consulted.
  assign pend_vec = (state == IDLE) ? (pending & ~mask) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_valid  <= 1'b0;
      vec_id     <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_valid) begin
            vec_id    <= enc_code;
            vec_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (vec_ready) begin
            vec_valid  <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          vec_valid  <= 1'b0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch with a behavioural 8-input priority encoder in the loop.
module tb_irq_dispatch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:7] irq_in;
  logic [0:7] mask;
  logic [0:7] pend_vec;
  logic [2:0] enc_code;
  logic       enc_valid;
  logic       vec_valid;
  logic [2:0] vec_id;
  logic       vec_ready;
  logic       eoi;
  logic       in_service;
  logic [0:7] pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_dispatch #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask      (mask),
    .pend_vec  (pend_vec),
    .enc_code  (enc_code),
    .enc_valid (enc_valid),
    .vec_valid (vec_valid),
    .vec_id    (vec_id),
    .vec_ready (vec_ready),
    .eoi       (eoi),
    .in_service(in_service),
    .pending   (pending)
  );

  // Highest-index set bit wins.
  always_comb begin
    enc_code  = 3'd0;
    enc_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pend_vec[i]) begin
        enc_code  = 3'(i);
        enc_valid = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic serve();
    vec_ready = 1'b1;
    tick(1);
    vec_ready = 1'b0;
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mask = '0; vec_ready = 1'b0; eoi = 1'b0;
    #12;
    check("rst_vec_valid", 32'(vec_valid), 32'd0);
    check("rst_vec_id", 32'(vec_id), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    check("rst_pending", 32'(pending), 32'h00);
    check("rst_pend_vec", 32'(pend_vec), 32'h00);
    rst_n = 1'b1;
    tick(2);

    // 1: single edge on source 3
    irq_in[3] = 1'b1;
    tick(2);
    check("t1_pending_early", 32'(pending), 32'h00);
    tick(1);
    check("t1_pending", 32'(pending), 32'(8'b00010000));
    check("t1_no_offer_yet", 32'(vec_valid), 32'd0);
    tick(1);
    check("t1_vec_valid", 32'(vec_valid), 32'd1);
    check("t1_vec_id", 32'(vec_id), 32'd3);
    vec_ready = 1'b1;
    tick(1);
    vec_ready = 1'b0;
    check("t1_in_service", 32'(in_service), 32'd1);
    check("t1_valid_drop", 32'(vec_valid), 32'd0);
    check("t1_pending_clr", 32'(pending), 32'h00);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    check("t1_eoi", 32'(in_service), 32'd0);
    irq_in = '0;
    tick(4);

    // 2: simultaneous edges on 1 and 6, plus ready+eoi together in OFFER
    irq_in[1] = 1'b1; irq_in[6] = 1'b1;
    tick(3);
    check("t2_pending", 32'(pending), 32'(8'b01000010));
    tick(1);
    check("t2_first_id", 32'(vec_id), 32'd6);
    serve();
    tick(1);
    check("t2_second_valid", 32'(vec_valid), 32'd1);
    check("t2_second_id", 32'(vec_id), 32'd1);
    vec_ready = 1'b1; eoi = 1'b1;
    tick(1);
    vec_ready = 1'b0; eoi = 1'b0;
    check("t2_pending_empty", 32'(pending), 32'h00);
    check("t2_eoi_in_offer_ignored", 32'(in_service), 32'd1);
    tick(1);
    check("t2_still_service", 32'(in_service), 32'd1);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    check("t2_eoi", 32'(in_service), 32'd0);
    irq_in = '0;
    tick(4);

    // 3: masked source latches but is not offered until unmasked
    mask[5] = 1'b1;
    irq_in[5] = 1'b1;
    tick(5);
    check("t3_pending", 32'(pending), 32'(8'b00000100));
    check("t3_masked_no_offer", 32'(vec_valid), 32'd0);
    check("t3_pend_vec_masked", 32'(pend_vec), 32'h00);
    mask = '0;
    tick(1);
    check("t3_unmask_valid", 32'(vec_valid), 32'd1);
    check("t3_unmask_id", 32'(vec_id), 32'd5);
    serve();
    irq_in = '0;
    tick(4);

    // 4: higher-priority arrival during OFFER does not displace the offer
    irq_in[2] = 1'b1;
    tick(4);
    check("t4_id2", 32'(vec_id), 32'd2);
    irq_in[7] = 1'b1;
    tick(4);
    check("t4_pending_both", 32'(pending), 32'(8'b00100001));
    check("t4_id_frozen", 32'(vec_id), 32'd2);
    check("t4_still_valid", 32'(vec_valid), 32'd1);
    vec_ready = 1'b1;
    tick(1);
    vec_ready = 1'b0;
    check("t4_pending_after_accept", 32'(pending), 32'(8'b00000001));
    tick(2);
    check("t4_no_offer_in_service", 32'(vec_valid), 32'd0);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    tick(1);
    check("t4_id7_valid", 32'(vec_valid), 32'd1);
    check("t4_id7", 32'(vec_id), 32'd7);
    serve();
    irq_in = '0;
    tick(4);

    // 5: new edge on source 4 coinciding with its accept keeps it pending
    irq_in[4] = 1'b1;
    tick(4);
    check("t5_id4", 32'(vec_id), 32'd4);
    irq_in[4] = 1'b0;
    tick(4);
    irq_in[4] = 1'b1;
    tick(2);
    vec_ready = 1'b1;
    tick(1);
    vec_ready = 1'b0;
    check("t5_set_wins", 32'(pending), 32'(8'b00001000));
    check("t5_in_service", 32'(in_service), 32'd1);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    tick(1);
    check("t5_reoffer_valid", 32'(vec_valid), 32'd1);
    check("t5_reoffer_id", 32'(vec_id), 32'd4);
    vec_ready = 1'b1;
    tick(1);
    vec_ready = 1'b0;

    // 6: reset during SERVICE with a request pending
    irq_in[0] = 1'b1;
    tick(3);
    check("t6_pending_before_rst", 32'(pending), 32'(8'b10000000));
    check("t6_in_service_before_rst", 32'(in_service), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vec_valid", 32'(vec_valid), 32'd0);
    check("t6_rst_in_service", 32'(in_service), 32'd0);
    check("t6_rst_pending", 32'(pending), 32'h00);
    irq_in = '0;
    #11;
    rst_n = 1'b1;
    tick(6);
    check("t6_no_offer_after_rst", 32'(vec_valid), 32'd0);
    check("t6_pending_after_rst", 32'(pending), 32'h00);
    irq_in[0] = 1'b1;
    tick(4);
    check("t6_rerequest_valid", 32'(vec_valid), 32'd1);
    check("t6_rerequest_id", 32'(vec_id), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
